// File: rtl/acc_pkg.sv
// Shared definitions for the C2C read-side request sequencer.
package acc_pkg;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WHDR = 2'd1,
        WDAT = 2'd2
    } acc_state_e;

    // Source of the pop issued in the previous cycle (its data lands this cycle)
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WR   = 2'd1,
        SRC_WD   = 2'd2,
        SRC_RD   = 2'd3
    } acc_src_e;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    localparam int unsigned OBUF_DEPTH = 4;

    // Room for one more pop: buffered beats plus the one still in flight must stay below depth.
    // A dequeue in the current cycle is deliberately not credited.
    function automatic logic has_space(input logic [2:0] occ, input logic inflight);
        return ({1'b0, occ} + {3'b000, inflight}) < 4'(OBUF_DEPTH);
    endfunction

endpackage

// File: rtl/acc_obuf.sv
// Shift-register output FIFO; entry 0 is the head so outputs come straight from a register.
// Vacated entries are cleared, so the head reads all-zero whenever the buffer is empty.
module acc_obuf
    import acc_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = OBUF_DEPTH,
    localparam int unsigned OccW = $clog2(Depth + 1),
    localparam int unsigned IdxW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] head_o,
    output logic             valid_o,
    output logic [OccW-1:0]  occ_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [OccW-1:0]  occ_q, occ_d;
    logic             deq;
    logic             wr_ok;
    logic [IdxW-1:0]  widx;

    // Next-state: shift on dequeue, write new entry behind the last valid one
    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q;
        deq   = rd_en_i && (occ_q != '0);
        wr_ok = wr_en_i && (deq || (occ_q < OccW'(Depth)));
        widx  = IdxW'(deq ? (occ_q - OccW'(1)) : occ_q);
        if (deq) begin
            for (int unsigned i = 0; i < Depth - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[Depth-1] = '0;
        end
        if (wr_ok) begin
            mem_d[widx] = wr_data_i;
        end
        occ_d = occ_q + OccW'(wr_ok) - OccW'(deq);
    end

    // Storage and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign head_o  = mem_q[0];
    assign valid_o = (occ_q != '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/acc_req_arb.sv
// Read-side request sequencer: pops write-header/write-data/read-header FIFOs in arrival
// order (ACC_BIT from the access-order tracker) and serialises them into one TX packet stream.
// Optional sticky ordering check enabled by defining ACC_REQ_ARB_CHK_EN.
module acc_req_arb
    import acc_pkg::*;
#(
    parameter int unsigned HW   = 64,
    parameter int unsigned DW   = 128,
    parameter int unsigned LENW = 4
) (
    input  logic                            RCLK,
    input  logic                            RESET,
    input  logic                            ACC_BIT,
    input  logic                            WR_EMPTY,
    input  logic [HW-1:0]                   WR_DOUT,
    output logic                            WR_RDEN,
    input  logic                            WD_EMPTY,
    input  logic [DW-1:0]                   WD_DOUT,
    output logic                            WD_RDEN,
    input  logic                            RD_EMPTY,
    input  logic [HW-1:0]                   RD_DOUT,
    output logic                            RD_RDEN,
    output logic                            TX_VALID,
    input  logic                            TX_READY,
    output logic [((HW > DW) ? HW : DW)-1:0] TX_DATA,
    output logic                            TX_SOP,
    output logic                            TX_EOP,
    output logic                            TX_KIND,
    output logic                            ERR_ORDER
);

    localparam int unsigned TW = (HW > DW) ? HW : DW;
    localparam int unsigned EW = TW + 3;  // {kind, eop, sop, data}

    acc_state_e      state_q, state_d;
    acc_src_e        src_q, src_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [LENW-1:0] hdr_len;
    logic [2:0]      occ;
    logic            space;
    logic            enq;
    logic [EW-1:0]   enq_data;
    logic [EW-1:0]   head;

    assign hdr_len = WR_DOUT[LENW-1:0];
    assign space   = has_space(occ, src_q != SRC_NONE);

    // Pop sequencing: decide which FIFO to pop and track burst progress
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = SRC_NONE;
        last_d  = 1'b0;
        WR_RDEN = 1'b0;
        WD_RDEN = 1'b0;
        RD_RDEN = 1'b0;
        case (state_q)
            IDLE: begin
                if (ACC_BIT) begin
                    if (!WR_EMPTY && space) begin
                        WR_RDEN = 1'b1;
                        src_d   = SRC_WR;
                        state_d = WHDR;
                    end
                end else if (!RD_EMPTY && space) begin
                    RD_RDEN = 1'b1;
                    src_d   = SRC_RD;
                end
            end
            WHDR: begin
                // Header data is visible now; its length field seeds the beat counter
                cnt_d   = hdr_len;
                state_d = WDAT;
                if (!WD_EMPTY && space) begin
                    WD_RDEN = 1'b1;
                    src_d   = SRC_WD;
                    if (hdr_len == '0) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = hdr_len - LENW'(1);
                    end
                end
            end
            WDAT: begin
                if (!WD_EMPTY && space) begin
                    WD_RDEN = 1'b1;
                    src_d   = SRC_WD;
                    if (cnt_q == '0) begin
                        last_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LENW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, beat counter and in-flight pop tracking
    always_ff @(posedge RCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_NONE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    // Format the beat popped last cycle into a buffer entry
    always_comb begin
        enq      = 1'b0;
        enq_data = '0;
        case (src_q)
            SRC_WR: begin
                enq      = 1'b1;
                enq_data = {KIND_WR, 1'b0, 1'b1, TW'(WR_DOUT)};
            end
            SRC_WD: begin
                enq      = 1'b1;
                enq_data = {KIND_WR, last_q, 1'b0, TW'(WD_DOUT)};
            end
            SRC_RD: begin
                enq      = 1'b1;
                enq_data = {KIND_RD, 1'b1, 1'b1, TW'(RD_DOUT)};
            end
            default: enq = 1'b0;
        endcase
    end

    acc_obuf #(
        .Width (EW),
        .Depth (OBUF_DEPTH)
    ) u_obuf (
        .clk_i     (RCLK),
        .rst_i     (RESET),
        .wr_en_i   (enq),
        .wr_data_i (enq_data),
        .rd_en_i   (TX_READY),
        .head_o    (head),
        .valid_o   (TX_VALID),
        .occ_o     (occ)
    );

    assign TX_DATA = head[TW-1:0];
    assign TX_SOP  = head[TW];
    assign TX_EOP  = head[TW+1];
    assign TX_KIND = head[TW+2];

`ifdef ACC_REQ_ARB_CHK_EN
    logic [3:0] chk_q, chk_d;
    logic       err_q, err_d;
    logic       mism;

    // Count consecutive idle cycles where the ordered FIFO is empty but the other is not
    always_comb begin
        mism  = (state_q == IDLE) &&
                (ACC_BIT ? (WR_EMPTY && !RD_EMPTY) : (RD_EMPTY && !WR_EMPTY));
        chk_d = mism ? ((chk_q == 4'd15) ? chk_q : chk_q + 4'd1) : 4'd0;
        err_d = err_q | (chk_d == 4'd15);
    end

    // Saturating counter and sticky error flag
    always_ff @(posedge RCLK or posedge RESET) begin
        if (RESET) begin
            chk_q <= '0;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    assign ERR_ORDER = err_q;
`else
    assign ERR_ORDER = 1'b0;
`endif

endmodule

// File: doc/acc_req_arb.md
Name: acc_req_arb

Overview:
- Read-side request sequencer for the C2C link. Consumes the ordering bit from the access-order tracker and pops the write-header FIFO, write-data FIFO or read-header FIFO in original arrival order.
- Serialises the popped entries into one packet stream towards the link transmitter through a 4-entry output buffer.
- Its WR_RDEN/RD_RDEN outputs are the tracker's read-side enables, so the tracker's read pointer advances exactly once per header popped.

Parameters:
- HW, 64: header word width (write and read header FIFOs).
- DW, 128: data beat width; TX_DATA width is max(HW,DW), headers zero-extended.
- LENW, 4: write burst length field, HDR[LENW-1:0] = beats-1.

Ports:
- RCLK  in  1  clock, shared with the FIFO read sides and the tracker read counter.
- RESET  in  1  asynchronous, active-high reset.
- ACC_BIT  in  1  order bit for next header: 1 = write next, 0 = read next.
- WR_EMPTY  in  1  write-header FIFO empty.
- WR_DOUT  in  HW  write-header FIFO data, valid 1 cycle after WR_RDEN.
- WR_RDEN  out  1  write-header pop.
- WD_EMPTY  in  1  write-data FIFO empty.
- WD_DOUT  in  DW  write-data FIFO data, valid 1 cycle after WD_RDEN.
- WD_RDEN  out  1  write-data pop.
- RD_EMPTY  in  1  read-header FIFO empty.
- RD_DOUT  in  HW  read-header FIFO data, valid 1 cycle after RD_RDEN.
- RD_RDEN  out  1  read-header pop.
- TX_VALID  out  1  output beat valid.
- TX_READY  in  1  transmitter accepts the beat.
- TX_DATA  out  max(HW,DW)  beat payload.
- TX_SOP  out  1  first beat of packet.
- TX_EOP  out  1  last beat of packet.
- TX_KIND  out  1  1 = write packet, 0 = read packet.
- ERR_ORDER  out  1  sticky ordering error (optional feature only).

Behaviour:
- Reset (asynchronous, RESET=1): FSM = IDLE, beat counter = 0, in-flight flag = 0, output buffer empty. All outputs are 0: WR_RDEN, RD_RDEN, WD_RDEN, TX_VALID, TX_SOP, TX_EOP, TX_KIND, TX_DATA, ERR_ORDER. Reset mid-packet discards any partial packet. RESET must be applied together with the tracker and the FIFOs.
- Space condition: SPACE = (occ + inflight) < 4.
  - occ is the output buffer occupancy. inflight = 1 if any pop was issued in the previous cycle.
  - A dequeue in the current cycle is not credited.
- At most one of WR_RDEN, WD_RDEN, RD_RDEN is high in any cycle. WR_RDEN and RD_RDEN are never high together.
- FSM states and transitions:
  - IDLE, ACC_BIT=1, !WR_EMPTY, SPACE: assert WR_RDEN and go to WHDR.
  - IDLE, ACC_BIT=0, !RD_EMPTY, SPACE: assert RD_RDEN and stay in IDLE. The next cycle writes RD_DOUT to the buffer with SOP=1, EOP=1, KIND=0.
  - IDLE, selected FIFO empty: no pop, even if the other FIFO is non-empty. ACC_BIT alone decides order.
  - WHDR: write WR_DOUT to the buffer with SOP=1, EOP=0, KIND=1, and load the counter with WR_DOUT[LENW-1:0]. Go to WDAT. A WD pop is allowed in this same cycle if !WD_EMPTY and SPACE.
  - WDAT, !WD_EMPTY, SPACE: assert WD_RDEN. Each popped beat enters the buffer one cycle later with SOP=0 and KIND=1.
  - WDAT, counter is 0 at the pop: that beat is marked EOP=1 and the FSM returns to IDLE. Otherwise the counter decrements.
  - A length field of 0 means 1 data beat; the maximum is 2^LENW beats.
- ACC_BIT is sampled only in IDLE. WD_EMPTY stalls WDAT without bound, with no timeout.
- Back-to-back reads: one RD pop per cycle while SPACE holds and ACC_BIT=0.
- Output buffer: FIFO ordered, beat leaves on TX_VALID & TX_READY.
  - TX_* outputs come directly from the buffer head register.
  - Latency from pop to TX_VALID is 2 cycles when the buffer is empty.
  - Simultaneous enqueue and dequeue is legal at any occupancy reached via SPACE. The buffer never overflows.

Optional Feature:
- Macro: ACC_REQ_ARB_CHK_EN.
- Enabled: a 4-bit saturating counter increments each IDLE cycle in which the FIFO selected by ACC_BIT is empty and the other FIFO is non-empty. It clears otherwise. When it reaches 15, ERR_ORDER is set and stays 1 until RESET. Arbitration is unaffected.
- Disabled: the counter is absent and ERR_ORDER is tied to 0.

Decomposition:
- Shared package acc_pkg holds:
  - FSM state encoding: IDLE = 2'd0, WHDR = 2'd1, WDAT = 2'd2.
  - KIND_RD = 0 and KIND_WR = 1.
  - Output buffer depth constant OBUF_DEPTH = 4.
- One natural sub-module, acc_obuf: a 4-entry synchronous FIFO with an occupancy output, instantiated once.

Test Plan:
- Single read: RD FIFO holds one header 64'hA5, ACC_BIT=0, TX_READY=1 -> RD_RDEN for 1 cycle; 2 cycles later TX_VALID=1 with TX_DATA=64'hA5, SOP=1, EOP=1, KIND=0.
- Write burst: header with LEN=3 plus 4 data beats queued, ACC_BIT=1 -> 5 consecutive TX beats; header has SOP=1; beat 4 has EOP=1; KIND=1 on all; WR_RDEN high for 1 cycle and WD_RDEN for 4.
- Interleaved order: ACC_BIT sequence 1,0,1 with LEN=0 writes -> TX order W-hdr, W-dat, R, W-hdr, W-dat; WR_RDEN and RD_RDEN never high together.
- Backpressure: TX_READY=0 during an 8-beat burst -> pops stop once occ+inflight=4; no beat lost or duplicated after TX_READY returns to 1.
- Reset in WDAT after 2 of 4 beats -> all outputs 0, FSM in IDLE; a fresh read after reset emits correctly.
- With ACC_REQ_ARB_CHK_EN: ACC_BIT=1, WR_EMPTY=1, RD_EMPTY=0 for 15 cycles -> ERR_ORDER=1 and stays set; without the macro, ERR_ORDER stays 0.
